// File: rtl/mdu_issue_ctrl_if.sv
// Pipeline-side bundle for the MDU issue controller: E/D-stage requests in,
// MDU op code, busy/stall/done, stall-cycle counter and FSM state out.
interface mdu_issue_ctrl_if;
    logic [3:0]  E_i_MduOp;
    logic        E_i_Cancel;
    logic        D_i_MduUse;
    logic [3:0]  o_MduOp;
    logic        o_Busy;
    logic        o_Stall;
    logic        o_Done;
    logic [31:0] o_StallCycles;
    logic        o_DbgState;

    // Handshake: an op is accepted in the cycle it is presented with the
    // controller IDLE and not cancelled; o_MduOp echoes it combinationally that
    // cycle, and o_Stall holds D back until o_Done has committed HI/LO.
    modport master (
        output E_i_MduOp, E_i_Cancel, D_i_MduUse,
        input  o_MduOp, o_Busy, o_Stall, o_Done, o_StallCycles, o_DbgState
    );

    modport slave (
        input  E_i_MduOp, E_i_Cancel, D_i_MduUse,
        output o_MduOp, o_Busy, o_Stall, o_Done, o_StallCycles, o_DbgState
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// Issue/sequencing controller for the HI/LO multiply-divide unit.
// Define MDU_PERF_CNT_EN to build the saturating stall-cycle counter.
module mdu_issue_ctrl #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic                clk,
    input  logic                reset,
    mdu_issue_ctrl_if.slave     bus
);
    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    state_t     r_state;
    state_t     w_next_state;
    logic [3:0] r_cnt;
    logic [3:0] w_next_cnt;
    logic       w_valid_op;
    logic       w_long_op;
    logic       w_issue;

    assign w_valid_op = (bus.E_i_MduOp >= 4'd1) && (bus.E_i_MduOp <= 4'd7);
    assign w_long_op  = (bus.E_i_MduOp >= 4'd1) && (bus.E_i_MduOp <= 4'd4);
    assign w_issue    = (r_state == S_IDLE) && !bus.E_i_Cancel && w_valid_op;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                // MTHI/MTLO/READ pass straight through without occupying the unit
                if (w_issue && w_long_op) begin
                    w_next_state = S_BUSY;
                    w_next_cnt   = (bus.E_i_MduOp <= 4'd2) ? MULT_CNT : DIV_CNT;
                end
            end
            S_BUSY: begin
                w_next_cnt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    assign bus.o_MduOp    = w_issue ? bus.E_i_MduOp : 4'd0;
    assign bus.o_Busy     = (r_state == S_BUSY);
    assign bus.o_Done     = (r_state == S_BUSY) && (r_cnt == 4'd1);
    // Stall already in the issue cycle so a dependent op never reaches E while busy
    assign bus.o_Stall    = bus.D_i_MduUse &&
                            ((r_state == S_BUSY) || (w_issue && w_long_op));
    assign bus.o_DbgState = r_state;

`ifdef MDU_PERF_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cycles <= 32'd0;
        end else if (bus.o_Stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign bus.o_StallCycles = r_stall_cycles;
`else
    assign bus.o_StallCycles = 32'd0;
`endif
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: MULT/DIV timing, pass-through ops,
// flush gating, mid-operation reset and the optional stall counter.
module tb_mdu_issue_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

`ifdef MDU_PERF_CNT_EN
    localparam logic [31:0] PERF_AFTER_MULT  = 32'd6;
    localparam logic [31:0] PERF_AFTER_MULTU = 32'd12;
`else
    localparam logic [31:0] PERF_AFTER_MULT  = 32'd0;
    localparam logic [31:0] PERF_AFTER_MULTU = 32'd0;
`endif

    mdu_issue_ctrl_if bus ();

    mdu_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive inputs, sample outputs at the falling edge, advance past the rising edge.
    task automatic cyc(input logic rst, input logic [3:0] op, input logic cancel,
                       input logic use_d, input logic [3:0] e_op, input logic e_busy,
                       input logic e_stall, input logic e_done, input string tag);
        reset          = rst;
        bus.E_i_MduOp  = op;
        bus.E_i_Cancel = cancel;
        bus.D_i_MduUse = use_d;
        @(negedge clk);
        chk({tag, ".op"},    32'(bus.o_MduOp), 32'(e_op));
        chk({tag, ".busy"},  32'(bus.o_Busy),  32'(e_busy));
        chk({tag, ".stall"}, 32'(bus.o_Stall), 32'(e_stall));
        chk({tag, ".done"},  32'(bus.o_Done),  32'(e_done));
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset          = 1'b1;
        bus.E_i_MduOp  = 4'd0;
        bus.E_i_Cancel = 1'b0;
        bus.D_i_MduUse = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        cyc(0, 0, 0, 0, 0, 0, 0, 0, "reset_idle");
        chk("reset_state", 32'(bus.o_DbgState), 32'd0);
        chk("reset_perf", bus.o_StallCycles, 32'd0);

        // MULT with a dependent D instruction throughout
        cyc(0, 1, 0, 1, 1, 0, 1, 0, "mult_c0");
        cyc(0, 0, 0, 1, 0, 1, 1, 0, "mult_c1");
        cyc(0, 7, 0, 1, 0, 1, 1, 0, "mult_c2_op_ignored");
        cyc(0, 0, 1, 1, 0, 1, 1, 0, "mult_c3_cancel_busy");
        cyc(0, 0, 0, 1, 0, 1, 1, 0, "mult_c4");
        cyc(0, 0, 0, 1, 0, 1, 1, 1, "mult_c5_done");
        cyc(0, 0, 0, 1, 0, 0, 0, 0, "mult_c6_idle");
        chk("perf_after_mult", bus.o_StallCycles, PERF_AFTER_MULT);

        // DIV without a dependent D instruction, then READ
        cyc(0, 3, 0, 0, 3, 0, 0, 0, "div_c0");
        for (int i = 1; i <= 9; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 0, "div_busy");
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 1, "div_c10_done");
        cyc(0, 7, 0, 1, 7, 0, 0, 0, "read_after_div");

        // Pass-through and out-of-range ops
        cyc(0, 5, 0, 1, 5, 0, 0, 0, "mthi");
        cyc(0, 7, 0, 0, 7, 0, 0, 0, "read");
        cyc(0, 6, 0, 1, 6, 0, 0, 0, "mtlo");
        cyc(0, 9, 0, 1, 0, 0, 0, 0, "op9_none");
        cyc(0, 15, 0, 0, 0, 0, 0, 0, "op15_none");
        chk("passthru_state", 32'(bus.o_DbgState), 32'd0);

        // Flushed MULTU, then the same op unflushed
        cyc(0, 2, 1, 1, 0, 0, 0, 0, "multu_cancel");
        chk("cancel_state", 32'(bus.o_DbgState), 32'd0);
        cyc(0, 2, 0, 1, 2, 0, 1, 0, "multu_c0");
        chk("multu_state", 32'(bus.o_DbgState), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 1, 0, 1, 1, 0, "multu_busy");
        end
        cyc(0, 0, 0, 1, 0, 1, 1, 1, "multu_done");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "multu_idle");
        chk("perf_after_multu", bus.o_StallCycles, PERF_AFTER_MULTU);

        // DIVU aborted by reset in its third busy cycle
        cyc(0, 4, 0, 0, 4, 0, 0, 0, "divu_c0");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, "divu_c1");
        cyc(0, 0, 0, 0, 0, 1, 0, 0, "divu_c2");
        cyc(1, 0, 0, 0, 0, 1, 0, 0, "divu_c3_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "divu_after_reset");
        chk("abort_state", 32'(bus.o_DbgState), 32'd0);
        chk("abort_perf", bus.o_StallCycles, 32'd0);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, "abort_no_done");
        end

        // Fresh MULT after the abort
        cyc(0, 1, 0, 0, 1, 0, 0, 0, "mult2_c0");
        for (int i = 1; i <= 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 0, 0, "mult2_busy");
        end
        cyc(0, 0, 0, 0, 0, 1, 0, 1, "mult2_done");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, "mult2_idle");
        chk("mult2_state", 32'(bus.o_DbgState), 32'd0);
        chk("final_perf", bus.o_StallCycles, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
